uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Reset presetn is asynchronous and active-low; clock is pclk.
REQ-002 pclk  input  1  system/APB clock.
REQ-003 presetn  input  1  asynchronous active-low reset.
REQ-004 rxd  input  1  serial receive line, asynchronous to pclk, idle high.
REQ-005 voting_edge  input  1  one-cycle pulse from clock_gen at sub-bit counts 6, 7 and 8 of each 16x bit period.
REQ-006 sample_edge  input  1  one-cycle pulse from clock_gen at sub-bit count 9; marks the decision point of each bit.
REQ-007 wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 pen  input  1  parity enable.
REQ-009 eps  input  1  1 = even parity, 0 = odd parity.
REQ-010 stp  input  1  stick parity.
REQ-011 sample_clk_clr  output  1  one-cycle pulse that realigns the clock_gen receive divider to the start-bit falling edge.
REQ-012 rx_data  output  8  received character, right-justified, unused MSBs zero.
REQ-013 rx_valid  output  1  one-cycle pulse; rx_data, pe, fe and bi are valid in this cycle only.
REQ-014 pe / fe / bi  output  1 each  parity error / framing error / break indication for the current character.
REQ-015 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-016 rxd shall pass through a 2-flop synchronizer plus one history flop; the start condition is synced value 0 with history value 1.
REQ-017 The FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: on the start condition, sample_clk_clr shall pulse for exactly 1 cycle, wls/pen/eps/stp shall be latched, and the FSM shall go to START. A line held low with no preceding high shall not start a frame.
REQ-019 Vote register: each voting_edge captures the synced rxd into a 3-bit shift register. At sample_edge the bit value is the majority (2 of 3). The vote register shall clear after each sample_edge.
REQ-020 START: at sample_edge, a voted value of 1 is a false start; the FSM shall return to IDLE with no rx_valid. A voted value of 0 shall move the FSM to DATA with bit count 0.
REQ-021 DATA: at each sample_edge, the voted bit shall be written to rx_data index bit_cnt (LSB first). After bit wls+4 the FSM shall go to PARITY if pen=1, otherwise to STOP.
REQ-022 PARITY: the expected bit is ~eps when stp=1, otherwise XOR(data bits) XOR ~eps. pe=1 when the voted bit differs from the expected bit.
REQ-023 STOP: only the first stop bit is checked. fe=1 when the voted stop bit is 0. bi=1 when the data bits, the parity bit (if enabled) and the stop bit are all 0.
REQ-024 rx_valid shall assert in the cycle after the STOP sample_edge, and the FSM shall return to IDLE in that same cycle. pe/fe/bi shall be 0 whenever rx_valid is 0.
REQ-025 After a break or framing error, a new frame shall start only after rxd has been seen high and then falls again.
REQ-026 Latched configuration governs the whole frame; changes to wls/pen/eps/stp mid-frame shall have no effect until the next start.
REQ-027 When sample_edge and voting_edge coincide, vote capture shall occur before the decision (capture wins).
REQ-028 Latency: rx_valid shall occur a fixed 1 cycle after the final sample_edge.

Reset
REQ-029 On presetn low: FSM = IDLE; rx_data = 0; rx_valid, pe, fe, bi, rx_busy, sample_clk_clr = 0; vote register = 0; synchronizer flops = 1.
REQ-030 A reset during a frame shall abort it; no rx_valid shall be produced for the aborted frame.

Structure
REQ-031 Package uart_pkg shall hold the rx_state_e enum and the word-length encodings, shared with the transmitter.
REQ-032 The synchronizer shall be a single sub-module, bit_sync (2-flop, parameterised reset value).
REQ-033 The block shall instantiate no clock divider; all bit timing comes from voting_edge and sample_edge.

Verification
REQ-034 8N1, 0xA5, divisor 16 -> rx_valid once; rx_data=0xA5; pe=fe=bi=0; sample_clk_clr pulses once per frame.
REQ-035 7E1, 0x35, correct even parity -> rx_data=0x35, pe=0; same frame with parity bit flipped -> pe=1.
REQ-036 3-cycle low glitch on idle rxd -> START rejects it; no rx_valid; FSM back in IDLE.
REQ-037 8N1 with stop bit 0 and data 0x00 -> fe=1, bi=1; rxd held low afterwards -> no new frame until rxd goes high and then falls.
REQ-038 One of the three votes corrupted on every data bit of 0x3C -> rx_data=0x3C.
REQ-039 presetn asserted mid-DATA -> all outputs 0 immediately; next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, word-length select codes
// and small helpers used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam logic [1:0] WLS_5BIT = 2'b00;
    localparam logic [1:0] WLS_6BIT = 2'b01;
    localparam logic [1:0] WLS_7BIT = 2'b10;
    localparam logic [1:0] WLS_8BIT = 2'b11;

    // 2-of-3 majority used for the per-bit vote decision
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Index of the last data bit for a given word length select (wls + 4)
    function automatic logic [2:0] last_bit_idx(input logic [1:0] w);
        return {1'b0, w} + 3'd4;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit, with a
// selectable reset value so idle-high lines come out of reset idle.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic pclk,
    input  logic presetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, majority-votes each bit on clock_gen pulses
// and reports one character per frame with parity/framing/break status.
module uart_rx
    import uart_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       rxd,
    input  logic       voting_edge,
    input  logic       sample_edge,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       stp,
    output logic       sample_clk_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    rx_state_e  state, state_next;

    logic       rxd_s;
    logic       rxd_h;
    logic [1:0] flush_cnt;
    logic       primed;
    logic       start_cond;

    logic [2:0] vote;
    logic [2:0] vote_now;
    logic       bit_val;

    logic [1:0] cfg_wls;
    logic       cfg_pen;
    logic       cfg_eps;
    logic       cfg_stp;
    logic [2:0] bit_cnt;
    logic [7:0] data;
    logic       pe_acc;
    logic       par_zero;
    logic       par_exp;

    logic       load_cfg;
    logic       shift_bit;
    logic       check_par;
    logic       finish;

    bit_sync #(.RST_VAL(1'b1)) u_rxd_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (rxd),
        .q       (rxd_s)
    );

    // The synchronizer's reset value must drain before a falling edge is
    // believed, so a line held low through reset never starts a frame.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rxd_h     <= 1'b1;
            flush_cnt <= '0;
        end else begin
            rxd_h <= rxd_s;
            if (flush_cnt != 2'd3) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
        end
    end

    assign primed     = (flush_cnt == 2'd3);
    assign start_cond = primed & ~rxd_s & rxd_h;

    // A vote arriving together with the decision pulse is folded in first
    assign vote_now = voting_edge ? {vote[1:0], rxd_s} : vote;
    assign bit_val  = maj3(vote_now);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            vote <= '0;
        end else if (sample_edge || load_cfg) begin
            vote <= '0;
        end else if (voting_edge) begin
            vote <= {vote[1:0], rxd_s};
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        sample_clk_clr = 1'b0;
        load_cfg       = 1'b0;
        shift_bit      = 1'b0;
        check_par      = 1'b0;
        finish         = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (start_cond) begin
                    sample_clk_clr = 1'b1;
                    load_cfg       = 1'b1;
                    state_next     = RX_START;
                end
            end
            RX_START: begin
                if (sample_edge) begin
                    state_next = bit_val ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample_edge) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == last_bit_idx(cfg_wls)) begin
                        state_next = cfg_pen ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (sample_edge) begin
                    check_par  = 1'b1;
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample_edge) begin
                    finish     = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_busy = (state != RX_IDLE);

    // Unused upper data bits are cleared at start, so a full-width XOR is exact
    assign par_exp = cfg_stp ? ~cfg_eps : ((^data) ^ ~cfg_eps);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cfg_wls  <= '0;
            cfg_pen  <= 1'b0;
            cfg_eps  <= 1'b0;
            cfg_stp  <= 1'b0;
            bit_cnt  <= '0;
            data     <= '0;
            pe_acc   <= 1'b0;
            par_zero <= 1'b1;
        end else begin
            if (load_cfg) begin
                cfg_wls  <= wls;
                cfg_pen  <= pen;
                cfg_eps  <= eps;
                cfg_stp  <= stp;
                bit_cnt  <= '0;
                data     <= '0;
                pe_acc   <= 1'b0;
                par_zero <= 1'b1;
            end
            if (shift_bit) begin
                data[bit_cnt] <= bit_val;
                bit_cnt       <= bit_cnt + 3'd1;
            end
            if (check_par) begin
                pe_acc   <= (bit_val != par_exp);
                par_zero <= ~bit_val;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
        end else begin
            rx_valid <= finish;
            pe       <= finish & pe_acc;
            fe       <= finish & ~bit_val;
            bi       <= finish & ~bit_val & par_zero & (data == '0);
            if (finish) begin
                rx_data <= data;
            end
        end
    end

endmodule
